// File: rtl/soc_cfg_pkg.sv
// Shared definitions for the SoC configuration APB slave.
// Contents:
//   - word-index localparams for every mapped register (byte offset >> 2)
//   - the transfer FSM state enum
//   - the CFG0 field layout and a constant builder for it
//   - the read value and error flag returned for unmapped addresses
//   - a byte-strobe merge helper shared by the strobed RW registers
package soc_cfg_pkg;

  // Register word indices (byte offset >> 2)
  localparam logic [9:0] REG_HW_ID    = 10'd0;   // 0x00
  localparam logic [9:0] REG_FW_ID    = 10'd1;   // 0x04
  localparam logic [9:0] REG_CFG0     = 10'd2;   // 0x08
  localparam logic [9:0] REG_CFG1     = 10'd3;   // 0x0C
  localparam logic [9:0] REG_CFG2     = 10'd4;   // 0x10
  localparam logic [9:0] REG_TICK_LO  = 10'd5;   // 0x14
  localparam logic [9:0] REG_TICK_HI  = 10'd6;   // 0x18
  localparam logic [9:0] REG_SCRATCH  = 10'd7;   // 0x1C
  localparam logic [9:0] REG_CPU_HALT = 10'd8;   // 0x20

  // Response for any address outside the map (0x24..0xFFC)
  localparam logic [31:0] UNMAPPED_RDATA = 32'h0;
  localparam logic        UNMAPPED_ERR   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] rsv3;
    logic [3:0] uart_speedup;   // [27:24]
    logic [2:0] rsv2;
    logic [4:0] sram_log2;      // [20:16]
    logic [2:0] rsv1;
    logic [4:0] bootrom_log2;   // [12:8]
    logic [2:0] rsv0;
    logic       l2_ena;         // [4]
    logic [3:0] cpu_max;        // [3:0]
  } cfg0_t;

  function automatic cfg0_t make_cfg0(input int cpu_max, input int l2_ena,
                                      input int bootrom_log2, input int sram_log2,
                                      input int uart_speedup);
    cfg0_t c;
    c              = '0;
    c.cpu_max      = 4'(cpu_max);
    c.l2_ena       = (l2_ena != 0);
    c.bootrom_log2 = 5'(bootrom_log2);
    c.sram_log2    = 5'(sram_log2);
    c.uart_speedup = 4'(uart_speedup);
    return c;
  endfunction

  // Replace only the bytes whose strobe bit is set
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/soc_cfg_apb.sv
// APB slave publishing the SoC build configuration to firmware.
// Read-only words describe the hardware ID, CPU count, cache geometry,
// memory sizes and UART speed-up; writable words hold a firmware ID, a
// scratch word and the per-CPU halt requests. A free-running 64-bit tick
// counter is read atomically: reading TICK_LO captures the upper word into
// a shadow that TICK_HI returns later.
//
// Ports:
//   i_clk, i_nrst      clock, asynchronous active-low reset
//   i_psel, i_penable  APB select / enable
//   i_pwrite           1 = write
//   i_paddr[11:0]      byte address, bits [1:0] ignored
//   i_pwdata[31:0]     write data
//   i_pstrb[3:0]       byte strobes (FW_ID and SCRATCH only)
//   o_prdata[31:0]     read data, valid while o_pready = 1
//   o_pready           one-cycle transfer-complete pulse
//   o_pslverr          error response, valid while o_pready = 1
//   o_cpu_halt         per-CPU halt request
//
// Transfer timing: the first cycle with i_psel & i_penable moves IDLE to
// WAIT; WAIT counts down WAIT_STATES cycles and then commits (read data,
// error flag, write, tick capture) on the edge into RESP, where o_pready
// is high for one cycle.
module soc_cfg_apb
  import soc_cfg_pkg::*;
#(
  parameter int          CPU_MAX       = 1,
  parameter logic [31:0] HW_ID         = 32'h2022_1101,
  parameter int          ILOG2_LINES   = 7,
  parameter int          ILOG2_NWAYS   = 2,
  parameter int          DLOG2_LINES   = 7,
  parameter int          DLOG2_NWAYS   = 2,
  parameter int          L2_ENA        = 0,
  parameter int          L2_LOG2_NWAYS = 4,
  parameter int          L2_LOG2_LINES = 9,
  parameter int          BOOTROM_LOG2  = 16,
  parameter int          SRAM_LOG2     = 18,
  parameter int          UART_SPEEDUP  = 0,
  parameter int          WAIT_STATES   = 0,
  parameter int          HALT_RST      = 0
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_psel,
  input  logic               i_penable,
  input  logic               i_pwrite,
  input  logic [11:0]        i_paddr,
  input  logic [31:0]        i_pwdata,
  input  logic [3:0]         i_pstrb,
  output logic [31:0]        o_prdata,
  output logic               o_pready,
  output logic               o_pslverr,
  output logic [CPU_MAX-1:0] o_cpu_halt
);

  localparam cfg0_t       CFG0_VAL  = make_cfg0(CPU_MAX, L2_ENA, BOOTROM_LOG2,
                                                SRAM_LOG2, UART_SPEEDUP);
  localparam logic [31:0] CFG1_VAL  = {16'h0, 4'(DLOG2_NWAYS), 4'(DLOG2_LINES),
                                       4'(ILOG2_NWAYS), 4'(ILOG2_LINES)};
  // L2 geometry is only meaningful when an L2 is actually built
  localparam logic [31:0] CFG2_VAL  = (L2_ENA != 0)
                                      ? {24'h0, 4'(L2_LOG2_LINES), 4'(L2_LOG2_NWAYS)}
                                      : 32'h0;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [CPU_MAX-1:0] HALT_INIT = HALT_RST[CPU_MAX-1:0];

  state_t             state;
  state_t             state_next;
  logic [3:0]         wait_cnt;
  logic [63:0]        tick;
  logic [31:0]        tick_hi;
  logic [31:0]        fw_id;
  logic [31:0]        scratch;
  logic [CPU_MAX-1:0] cpu_halt;

  logic [9:0]         word;
  logic               access;
  logic               commit;
  logic [31:0]        rd_val;
  logic               rd_err;
  logic               addr_unused;

  assign word        = i_paddr[11:2];
  assign addr_unused = ^i_paddr[1:0];
  assign access      = i_psel & i_penable;

  // ---- free-running tick counter ----
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) tick <= '0;
    else         tick <= tick + 64'd1;
  end

  // ---- FSM: state register ----
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_next;
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (access) state_next = WAIT;
      WAIT: begin
        // Dropping select or enable mid-access abandons the transfer
        if (!access)             state_next = IDLE;
        else if (wait_cnt == '0) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- FSM: outputs (commit strobe and read mux) ----
  always_comb begin
    commit = (state == WAIT) && access && (wait_cnt == '0);
    rd_val = '0;
    rd_err = 1'b0;
    case (word)
      REG_HW_ID:    rd_val = HW_ID;
      REG_FW_ID:    rd_val = fw_id;
      REG_CFG0:     rd_val = CFG0_VAL;
      REG_CFG1:     rd_val = CFG1_VAL;
      REG_CFG2:     rd_val = CFG2_VAL;
      REG_TICK_LO:  rd_val = tick[31:0];
      REG_TICK_HI:  rd_val = tick_hi;
      REG_SCRATCH:  rd_val = scratch;
      REG_CPU_HALT: rd_val[CPU_MAX-1:0] = cpu_halt;
      default: begin
        rd_val = UNMAPPED_RDATA;
        rd_err = UNMAPPED_ERR;
      end
    endcase
  end

  // ---- wait-state counter ----
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wait_cnt <= '0;
    end else if (state == IDLE && access) begin
      wait_cnt <= WAIT_INIT;
    end else if (state == WAIT && access && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // ---- registered response ----
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_pready  <= 1'b0;
      o_prdata  <= '0;
      o_pslverr <= 1'b0;
    end else begin
      o_pready <= commit;
      if (commit) begin
        o_prdata  <= rd_val;
        o_pslverr <= rd_err;
      end
    end
  end

  // ---- register file: writes and tick shadow capture ----
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      fw_id    <= '0;
      scratch  <= '0;
      cpu_halt <= HALT_INIT;
      tick_hi  <= '0;
    end else if (commit) begin
      if (i_pwrite) begin
        case (word)
          REG_FW_ID:    fw_id    <= strb_merge(fw_id, i_pwdata, i_pstrb);
          REG_SCRATCH:  scratch  <= strb_merge(scratch, i_pwdata, i_pstrb);
          REG_CPU_HALT: cpu_halt <= i_pwdata[CPU_MAX-1:0];
          default: ;
        endcase
      end else if (word == REG_TICK_LO) begin
        // Same counter value as the low word returned on this edge
        tick_hi <= tick[63:32];
      end
    end
  end

  assign o_cpu_halt = cpu_halt;

endmodule

// File: tb/tb_soc_cfg_apb.sv
module tb_soc_cfg_apb;

  localparam int WS       = 3;
  localparam int CPUS     = 4;
  localparam int HALT_RST = 5;
  localparam int UART     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // main DUT bus
  logic        psel = 0, penable = 0, pwrite = 0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [3:0]  halt;

  // second DUT: default geometry, zero wait states, L2 present
  logic        psel0 = 0, penable0 = 0, pwrite0 = 0;
  logic [11:0] paddr0 = '0;
  logic [31:0] pwdata0 = '0;
  logic [3:0]  pstrb0 = '0;
  logic [31:0] prdata0;
  logic        pready0, pslverr0;
  logic [0:0]  halt0;

  soc_cfg_apb #(.CPU_MAX(CPUS), .WAIT_STATES(WS), .HALT_RST(HALT_RST),
                .UART_SPEEDUP(UART)) dut (
    .i_clk(clk), .i_nrst(rst_n), .i_psel(psel), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata), .o_pready(pready), .o_pslverr(pslverr), .o_cpu_halt(halt));

  soc_cfg_apb #(.L2_ENA(1)) dut0 (
    .i_clk(clk), .i_nrst(rst_n), .i_psel(psel0), .i_penable(penable0),
    .i_pwrite(pwrite0), .i_paddr(paddr0), .i_pwdata(pwdata0), .i_pstrb(pstrb0),
    .o_prdata(prdata0), .o_pready(pready0), .o_pslverr(pslverr0), .o_cpu_halt(halt0));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint      cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [63:0] tick_base = 0;
  longint      cyc_base  = 0;
  logic [31:0] m_fw = 0, m_scr = 0, m_shadow = 0;
  logic [3:0]  m_halt = HALT_RST[3:0];

  bit          p_valid = 0;
  logic [11:0] p_addr;
  logic        p_wr;
  logic [31:0] p_wdata;
  logic [3:0]  p_strb;
  longint      p_a0;
  logic [31:0] exp_rdata;
  logic        exp_err;
  bit          chk_en = 0;

  function automatic logic [63:0] tick_now();
    return tick_base + 64'(cyc - cyc_base);
  endfunction

  function automatic logic [31:0] model_read(input int w, input logic [63:0] t, output logic err);
    err = 0;
    case (w)
      0: return 32'h2022_1101;
      1: return m_fw;
      2: return 32'(CPUS | (0 << 4) | (16 << 8) | (18 << 16) | (UART << 24));
      3: return 32'(7 | (2 << 4) | (7 << 8) | (2 << 12));
      4: return 32'h0;
      5: return t[31:0];
      6: return m_shadow;
      7: return m_scr;
      8: return {28'h0, m_halt};
      default: begin err = 1; return 32'h0; end
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] o, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // single compare process: checks the main DUT every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_rdy;
      chk("cpu_halt", halt, m_halt);
      exp_rdy = p_valid && (cyc == p_a0 + 2 + WS);
      chk("pready", pready, exp_rdy);
      if (exp_rdy) begin
        if (!p_wr) chk("prdata", prdata, exp_rdata);
        chk("pslverr", pslverr, exp_err);
        p_valid = 0;
      end
      if (p_valid && (cyc == p_a0 + 1 + WS)) begin
        int w;
        logic [63:0] t;
        w = int'(p_addr[11:2]);
        t = tick_now();
        exp_rdata = model_read(w, t, exp_err);
        if (!p_wr && w == 5) m_shadow = t[63:32];
        if (p_wr) begin
          if (w == 1) m_fw  = merge_bytes(m_fw, p_wdata, p_strb);
          if (w == 7) m_scr = merge_bytes(m_scr, p_wdata, p_strb);
          if (w == 8) m_halt = p_wdata[3:0];
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er,
                      output int lat);
    bit got;
    @(negedge clk);
    psel = 1; penable = 0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
    @(negedge clk);
    penable = 1;
    p_addr = a; p_wr = w; p_wdata = d; p_strb = s; p_a0 = cyc; p_valid = 1;
    got = 0; lat = 0; rd = 'x; er = 'x;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (pready) begin got = 1; rd = prdata; er = pslverr; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h no pready within 40 cycles", a);
      p_valid = 0;
    end
    psel = 0; penable = 0;
  endtask

  task automatic xfer0(input logic [11:0] a, output logic [31:0] rd, output logic er,
                       output int lat);
    bit got;
    @(negedge clk);
    psel0 = 1; penable0 = 0; paddr0 = a; pwrite0 = 0; pwdata0 = 0; pstrb0 = 0;
    @(negedge clk);
    penable0 = 1;
    got = 0; lat = 0; rd = 'x; er = 'x;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (pready0) begin got = 1; rd = prdata0; er = pslverr0; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout0 addr=%h no pready within 20 cycles", a);
    end
    psel0 = 0; penable0 = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;

    // reset state
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", pready, 1'b0);
    chk("rst_pslverr", pslverr, 1'b0);
    chk("rst_halt", halt, 4'h5);
    chk("rst_halt0", halt0, 1'b0);

    // zero-wait-state DUT: latency and L2-enabled geometry
    xfer0(12'h000, rd, er, lat);
    chk("d0_hwid", rd, 32'h2022_1101);
    chk("d0_hwid_err", er, 1'b0);
    chk("d0_lat", lat, 2);
    xfer0(12'h010, rd, er, lat);
    chk("d0_cfg2", rd, 32'h0000_0094);
    xfer0(12'h008, rd, er, lat);
    chk("d0_cfg0", rd, 32'h0012_1011);

    // main DUT directed
    xfer(12'h000, 0, 0, 0, rd, er, lat);
    chk("hwid", rd, 32'h2022_1101);
    chk("hwid_lat", lat, 5);
    xfer(12'h01C, 1, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    chk("scr_wr_lat", lat, 5);
    xfer(12'h01C, 0, 0, 0, rd, er, lat);
    chk("scr_rd", rd, 32'h00BB_00DD);
    chk("scr_rd_lat", lat, 5);
    xfer(12'h020, 1, 32'h0000_00FF, 4'hF, rd, er, lat);
    chk("halt_after_wr", halt, 4'hF);
    xfer(12'h020, 0, 0, 0, rd, er, lat);
    chk("halt_rd", rd, 32'h0000_000F);
    xfer(12'h040, 0, 0, 0, rd, er, lat);
    chk("unmapped_rd", rd, 32'h0);
    chk("unmapped_err", er, 1'b1);
    xfer(12'h008, 1, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    chk("ro_wr_err", er, 1'b0);
    xfer(12'h008, 0, 0, 0, rd, er, lat);
    chk("cfg0", rd, 32'h0312_1004);
    xfer(12'h00C, 0, 0, 0, rd, er, lat);
    chk("cfg1", rd, 32'h0000_2727);
    xfer(12'h010, 0, 0, 0, rd, er, lat);
    chk("cfg2_no_l2", rd, 32'h0);

    // tick: the read commits 6 cycles after the forcing cycle
    @(negedge clk);
    force dut.tick = 64'h0000_0001_FFFF_FFF8;
    tick_base = 64'h0000_0001_FFFF_FFF8;
    cyc_base  = cyc;
    #1 release dut.tick;
    xfer(12'h014, 0, 0, 0, rd, er, lat);
    chk("tick_lo", rd, 32'hFFFF_FFFE);
    repeat (10) @(negedge clk);
    xfer(12'h018, 0, 0, 0, rd, er, lat);
    chk("tick_hi", rd, 32'h0000_0001);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      int          sel;
      logic [11:0] a;
      sel = $urandom_range(0, 11);
      if (sel <= 8)       a = 12'(sel * 4);
      else if (sel == 9)  a = 12'h024;
      else if (sel == 10) a = 12'($urandom_range(9, 1023) * 4);
      else                a = 12'h014;
      a[1:0] = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd, er, lat);
    end

    // asynchronous reset during WAIT of an FW_ID write
    @(negedge clk);
    psel = 1; penable = 0; paddr = 12'h004; pwrite = 1; pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(negedge clk);
    penable = 1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 0;
    chk_en = 0;
    m_fw = 0; m_scr = 0; m_shadow = 0; m_halt = HALT_RST[3:0];
    p_valid = 0; tick_base = 0; cyc_base = 0;
    @(negedge clk);
    chk("abort_pready", pready, 1'b0);
    chk("abort_halt", halt, 4'h5);
    psel = 0; penable = 0;
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    xfer(12'h004, 0, 0, 0, rd, er, lat);
    chk("abort_fwid", rd, 32'h0);
    chk("abort_next_lat", lat, 5);
    xfer(12'h004, 1, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    xfer(12'h004, 0, 0, 0, rd, er, lat);
    chk("fwid_rd", rd, 32'hCAFE_F00D);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
